alu_seq_core: RTL and testbench

Parametrised sequential ALU core for Tiny Tapeout tops. Operands A and B are loaded bit-serially through a shared one-bit port. Operations run on a start/busy/done handshake: single-cycle logic and arithmetic, barrel shifts, and an optional multi-cycle shift-add multiplier with a double-width product. The core sits between the pin-mapping top level and the output mux, and replaces the fixed 8-bit combinational ALU path.

---
 rtl/alu_seq_core.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU core with bit-serial operand loading.
//
// Operands A and B are shifted in MSB-first through data_in (sel_ab picks
// the target, save_bit strobes a bit). A start pulse in IDLE launches the
// operation selected by op. Single-cycle ops finish at the start edge.
// MUL is a WIDTH-iteration shift-add unit when ALU_SEQ_MUL_EN is defined.
// Without that macro, op 110 completes in one cycle with result 0 and V=Z=1.
//
// Parameters:
//   WIDTH     operand/result width (power of two, 4..32)
//   SW        shift-amount width, derived from WIDTH
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   ena       clock enable; low freezes all state
//   data_in   serial operand bit
//   sel_ab    0 = load A, 1 = load B
//   save_bit  shift data_in into the selected operand (IDLE, start low)
//   start     launch operation (sampled in IDLE only)
//   op        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL,
//             110 MUL, 111 SHR
//   shamt     shift amount for SHL/SHR
//   result    registered result (low half for MUL)
//   result_hi MUL high half, 0 otherwise
//   flags     {N,V,C,Z}
//   busy      high while the FSM is not IDLE
//   done      one-cycle completion pulse
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             data_in,
  input  logic             sel_ab,
  input  logic             save_bit,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    shamt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic v,
                                            input logic c);
    return {r[WIDTH-1], v, c, (r == '0)};
  endfunction

  // Single-cycle datapath: evaluated from the held operands while in IDLE
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0]        sc_res;
  logic                    sc_v, sc_c;
  logic [3:0]              sc_flags;

  assign a_s   = a_reg;
  assign b_s   = b_reg;
  assign add_w = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_w = {1'b0, a_reg} - {1'b0, b_reg};
  // The extra bit catches the last bit shifted out; it is 0 for shamt = 0.
  assign shl_w = {1'b0, a_reg} << shamt;
  assign shr_w = {a_reg, 1'b0} >> shamt;

  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = add_ovf(a_s, b_s, add_w[WIDTH-1:0]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = sub_ovf(a_s, b_s, sub_w[WIDTH-1:0]);
      end
      OP_AND: sc_res = a_reg & b_reg;
      OP_OR:  sc_res = a_reg | b_reg;
      OP_XOR: sc_res = a_reg ^ b_reg;
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
`ifndef ALU_SEQ_MUL_EN
      // No multiplier: a fixed result 0 with V set marks the op as unsupported.
      OP_MUL: sc_v = 1'b1;
`endif
      default: ;
    endcase
    sc_flags = pack_flags(sc_res, sc_v, sc_c);
  end

`ifdef ALU_SEQ_MUL_EN
  // Multiplier step: {acc_hi, mplr} is the running product; the multiplier
  // occupies the low half and is consumed one bit per iteration.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplr;
  logic [SW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, acc_hi} + ({(WIDTH+1){mplr[0]}} & {1'b0, a_reg});
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], mplr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (ena) begin
      if (state == IDLE && start && op == OP_MUL) begin
        acc_hi <= '0;
        mplr   <= b_reg;
      end else if (state == RUN) begin
        acc_hi <= mul_hi_nx;
        mplr   <= mul_lo_nx;
      end
    end
  end
`endif

  // Control FSM and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt       <= '0;
`endif
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= '0;
            end else begin
              state     <= DONE;
              busy      <= 1'b1;
              done      <= 1'b1;
              result    <= sc_res;
              result_hi <= '0;
              flags     <= sc_flags;
            end
`else
            state     <= DONE;
            busy      <= 1'b1;
            done      <= 1'b1;
            result    <= sc_res;
            result_hi <= '0;
            flags     <= sc_flags;
`endif
          end else if (save_bit) begin
            if (sel_ab) b_reg <= {b_reg[WIDTH-2:0], data_in};
            else        a_reg <= {a_reg[WIDTH-2:0], data_in};
          end
        end
`ifdef ALU_SEQ_MUL_EN
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == SW'(WIDTH - 1)) begin
            state     <= DONE;
            done      <= 1'b1;
            result    <= mul_lo_nx;
            result_hi <= mul_hi_nx;
            flags     <= pack_flags(mul_lo_nx, (mul_hi_nx != '0), (mul_hi_nx != '0));
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Testbench for alu_seq_core: randomized operations with a scoreboard.
// Stimulus pushes expected responses; a monitor pops them on each done.
module tb_alu_seq_core;

  localparam int W  = 8;
  localparam int SW = 3;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, ena, data_in, sel_ab, save_bit, start;
  logic [2:0]    op;
  logic [SW-1:0] shamt;
  logic [W-1:0]  result, result_hi;
  logic [3:0]    flags;
  logic          busy, done;

  logic          data16, sel16, save16, start16;
  logic [2:0]    op16;
  logic [3:0]    shamt16;
  logic [15:0]   result16, result_hi16;
  logic [3:0]    flags16;
  logic          busy16, done16;

  alu_seq_core #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .sel_ab(sel_ab),
    .save_bit(save_bit), .start(start), .op(op), .shamt(shamt),
    .result(result), .result_hi(result_hi), .flags(flags), .busy(busy), .done(done)
  );

  alu_seq_core #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .data_in(data16), .sel_ab(sel16),
    .save_bit(save16), .start(start16), .op(op16), .shamt(shamt16),
    .result(result16), .result_hi(result_hi16), .flags(flags16), .busy(busy16),
    .done(done16)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     r;
    longint     hi;
    logic [3:0] f;
    int         lat;
    int         t0;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           eedge  = 0;
  int           pops   = 0;
  int           npush  = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;

  always @(posedge clk) if (ena) eedge = eedge + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model written from the arithmetic rules of each op.
  function automatic void model(input int w, input int opc, input longint a, input longint b,
                                input int sh, output longint r, output longint hi,
                                output logic [3:0] f, output int lat);
    longint mask, half, sa, sb, ss, p;
    logic c, v;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa = (a >= half) ? a - (half << 1) : a;
    sb = (b >= half) ? b - (half << 1) : b;
    c = 1'b0; v = 1'b0; hi = 0; lat = 0; r = 0;
    case (opc)
      0: begin r = (a + b) & mask; c = (a + b) > mask; ss = sa + sb; v = (ss >= half) || (ss < -half); end
      1: begin r = (a - b) & mask; c = a < b;          ss = sa - sb; v = (ss >= half) || (ss < -half); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << sh) & mask; c = (sh != 0) && (((a >> (w - sh)) & 1) != 0); end
      7: begin r = a >> sh;          c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      default: begin
        if (MUL_EN) begin
          p = a * b; r = p & mask; hi = p >> w; c = (hi != 0); v = c; lat = w;
        end else begin
          v = 1'b1;
        end
      end
    endcase
    f = {(r >= half), v, c, (r == 0)};
  endfunction

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done && ena) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pops++;
        chk("result",    result,      e.r);
        chk("result_hi", result_hi,   e.hi);
        chk("flags",     flags,       e.f);
        chk("latency",   eedge - e.t0, e.lat);
      end
    end
  end

  task automatic load(input bit sel, input logic [W-1:0] v);
    bit e;
    for (int i = W - 1; i >= 0; i--) begin
      do begin
        e = ($urandom_range(0, 3) != 0);
        ena = e; sel_ab = sel; data_in = v[i]; save_bit = 1'b1;
        tick;
      end while (!e);
    end
    save_bit = 1'b0; ena = 1'b1;
    if (sel) mb = v; else ma = v;
  endtask

  task automatic chk_reset_vals();
    chk("rst_result",    result,    0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_flags",     flags,     0);
    chk("rst_busy",      busy,      0);
    chk("rst_done",      done,      0);
  endtask

  task automatic run_op(input int opc, input int sh, input bit rst_mid);
    exp_t       e;
    longint     r, hi;
    logic [3:0] f;
    int         lat, guard;
    model(W, opc, longint'(ma), longint'(mb), sh, r, hi, f, lat);
    ena = 1'b1; op = opc[2:0]; shamt = sh[SW-1:0]; start = 1'b1;
    tick;
    start = 1'b0;
    if (rst_mid) begin
      repeat (MUL_EN ? 3 : 0) tick;
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      ma = '0; mb = '0;
      tick;
      rst_n = 1'b1;
      return;
    end
    e.r = r; e.hi = hi; e.f = f; e.lat = lat; e.t0 = eedge;
    exp_q.push_back(e);
    npush++;
    // While busy, toggle ena and poke start/save_bit; both must be ignored.
    guard = 0;
    while (busy && guard < 200) begin
      ena      = ($urandom_range(0, 3) != 0);
      start    = $urandom_range(0, 1);
      save_bit = $urandom_range(0, 1);
      sel_ab   = $urandom_range(0, 1);
      data_in  = $urandom_range(0, 1);
      tick;
      guard++;
    end
    start = 1'b0; save_bit = 1'b0; ena = 1'b1;
    chk("busy_cleared", busy, 0);
    chk("done_seen", pops, npush);
  endtask

  task automatic load16(input bit sel, input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      sel16 = sel; data16 = v[i]; save16 = 1'b1;
      tick;
    end
    save16 = 1'b0;
  endtask

  initial begin
    longint     r16, h16;
    logic [3:0] f16;
    int         l16, opc;
    rst_n = 1'b0; ena = 1'b1; data_in = 0; sel_ab = 0; save_bit = 0; start = 0;
    op = '0; shamt = '0;
    data16 = 0; sel16 = 0; save16 = 0; start16 = 0; op16 = '0; shamt16 = '0;
    tick; tick;
    chk_reset_vals();
    rst_n = 1'b1;
    tick;

    load(0, 8'h5A); load(1, 8'h3C); run_op(0, 0, 0);
    load(0, 8'h3C);                 run_op(1, 0, 0);
    load(0, 8'h01); load(1, 8'h02); run_op(1, 0, 0);
    load(0, 8'hFF); load(1, 8'hFF); run_op(6, 0, 0);
    load(0, 8'h81);                 run_op(5, 1, 0);
                                    run_op(7, 0, 0);
    load(1, 8'hA7);                 run_op(6, 0, 0);
    run_op(6, 0, 1);
    load(0, 8'h33); load(1, 8'h44); run_op(0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) load(0, W'($urandom));
      if ($urandom_range(0, 2) == 0) load(1, W'($urandom));
      opc = $urandom_range(0, 7);
      run_op(opc, $urandom_range(0, W - 1), 0);
    end

    load16(0, 16'hFFFF); load16(1, 16'h0001);
    model(16, 0, 64'hFFFF, 64'h1, 0, r16, h16, f16, l16);
    op16 = 3'b000; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    chk("w16_done",   done16,   1);
    chk("w16_result", result16, r16);
    chk("w16_flags",  flags16,  f16);
    tick;
    chk("w16_idle",   busy16,   0);

    repeat (5) tick;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
